// File: rtl/dcache_line_adaptor.sv
// ============================================================================
// Module      : dcache_line_adaptor
// Description : Converts one 256-bit dcache line transaction into a BEATS x
//               BEAT_W burst and reassembles read bursts into a full line.
//               Optional perf counters: define DCACHE_ADAPTOR_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_line_adaptor #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               line_address,
  input  logic                      line_read,
  input  logic                      line_write,
  input  logic [BEAT_W*BEATS-1:0]   line_wdata,
  output logic [BEAT_W*BEATS-1:0]   line_rdata,
  output logic                      line_resp,
  output logic [31:0]               burst_address,
  output logic                      burst_read,
  output logic                      burst_write,
  output logic [BEAT_W-1:0]         burst_wdata,
  input  logic [BEAT_W-1:0]         burst_rdata,
  input  logic                      burst_resp
`ifdef DCACHE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]               perf_rd_lines,
  output logic [31:0]               perf_wr_lines
`endif
);

  localparam int                 c_LINE_W    = BEAT_W * BEATS;
  localparam int                 c_CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(BEATS - 1);
  localparam logic [31:0]        c_ADDR_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_addr;
  logic [c_LINE_W-1:0]  r_wdata;
  logic [c_LINE_W-1:0]  r_rbuf;
  logic [c_LINE_W-1:0]  r_line;
  logic [c_LINE_W-1:0]  w_rbuf_next;
  logic                 w_accept;
  logic                 w_beat;
  logic                 w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_beat       = 1'b0;
    w_last       = 1'b0;
    burst_read   = 1'b0;
    burst_write  = 1'b0;
    line_resp    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Write takes priority when both requests are raised together.
        w_accept = line_read | line_write;
        if (line_write) begin
          w_state_next = S_WR;
        end else if (line_read) begin
          w_state_next = S_RD;
        end
      end
      S_RD: begin
        burst_read = 1'b1;
        w_beat     = burst_resp;
        w_last     = burst_resp && (r_cnt == c_LAST);
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_WR: begin
        burst_write = 1'b1;
        w_beat      = burst_resp;
        w_last      = burst_resp && (r_cnt == c_LAST);
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        line_resp    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_rbuf_next = r_rbuf;
    w_rbuf_next[r_cnt*BEAT_W +: BEAT_W] = burst_rdata;
  end

  // Reads assemble in a shadow buffer so line_rdata only moves on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_line  <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= line_address & c_ADDR_MASK;
        r_wdata <= line_wdata;
        r_cnt   <= '0;
      end
      if (w_beat) begin
        r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
        if (r_state == S_RD) begin
          r_rbuf <= w_rbuf_next;
          if (w_last) begin
            r_line <= w_rbuf_next;
          end
        end
      end
    end
  end

  assign line_rdata    = r_line;
  assign burst_address = r_addr;
  assign burst_wdata   = r_wdata[r_cnt*BEAT_W +: BEAT_W];

`ifdef DCACHE_ADAPTOR_PERF_EN
  logic        r_is_wr;
  logic [31:0] r_perf_rd;
  logic [31:0] r_perf_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_wr   <= 1'b0;
      r_perf_rd <= '0;
      r_perf_wr <= '0;
    end else begin
      if (w_accept) begin
        r_is_wr <= line_write;
      end
      if (r_state == S_DONE) begin
        if (r_is_wr) begin
          if (r_perf_wr != 32'hFFFF_FFFF) begin
            r_perf_wr <= r_perf_wr + 32'd1;
          end
        end else if (r_perf_rd != 32'hFFFF_FFFF) begin
          r_perf_rd <= r_perf_rd + 32'd1;
        end
      end
    end
  end

  assign perf_rd_lines = r_perf_rd;
  assign perf_wr_lines = r_perf_wr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_line_adaptor.sv
// ============================================================================
// Module      : tb_dcache_line_adaptor
// Description : Randomized self-checking bench for dcache_line_adaptor with a
//               transaction-level reference model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_line_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  line_address = '0;
  logic         line_read = 1'b0;
  logic         line_write = 1'b0;
  logic [255:0] line_wdata = '0;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;
`ifdef DCACHE_ADAPTOR_PERF_EN
  logic [31:0]  perf_rd_lines;
  logic [31:0]  perf_wr_lines;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit nogap = 1'b0;
  bit noise = 1'b0;
  int resp_cnt = 0;
  logic [63:0] rd_q[$];
  logic [63:0] wcap[$];

  dcache_line_adaptor #(.BEAT_W(64), .BEATS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .line_address  (line_address),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
`ifdef DCACHE_ADAPTOR_PERF_EN
    ,
    .perf_rd_lines (perf_rd_lines),
    .perf_wr_lines (perf_wr_lines)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding line; kind 0=none 1=read 2=write.
  int           m_kind;
  int           m_beats;
  bit           m_resp;
  bit           m_last_rd;
  logic [31:0]  m_addr;
  logic [255:0] m_wline;
  logic [255:0] m_rbuf;
  logic [255:0] m_line;
  int           m_prd;
  int           m_pwr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind = 0; m_beats = 0; m_resp = 0; m_last_rd = 0;
      m_addr = '0; m_wline = '0; m_rbuf = '0; m_line = '0;
      m_prd = 0; m_pwr = 0;
    end else if (m_resp) begin
      m_resp = 0;
      if (m_last_rd) m_prd++;
      else m_pwr++;
    end else if (m_kind == 0) begin
      if (line_write || line_read) begin
        m_kind  = line_write ? 2 : 1;
        m_addr  = {line_address[31:5], 5'b0};
        m_wline = line_wdata;
        m_beats = 0;
      end
    end else if (burst_resp) begin
      if (m_kind == 1) m_rbuf[64*m_beats +: 64] = burst_rdata;
      m_beats++;
      if (m_beats == 4) begin
        m_last_rd = (m_kind == 1);
        if (m_kind == 1) m_line = m_rbuf;
        m_kind = 0;
        m_resp = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("line_resp", 256'(line_resp), 256'(m_resp));
      chk("burst_read", 256'(burst_read), 256'(m_kind == 1));
      chk("burst_write", 256'(burst_write), 256'(m_kind == 2));
      chk("line_rdata", line_rdata, m_line);
      chk("burst_address", 256'(burst_address), 256'(m_addr));
      if (m_kind == 2) chk("burst_wdata", 256'(burst_wdata), 256'(m_wline[64*m_beats +: 64]));
`ifdef DCACHE_ADAPTOR_PERF_EN
      chk("perf_rd_lines", 256'(perf_rd_lines), 256'(m_prd));
      chk("perf_wr_lines", 256'(perf_wr_lines), 256'(m_pwr));
`endif
      if (line_resp) resp_cnt++;
      if (burst_write && burst_resp && rst) wcap.push_back(burst_wdata);
    end
  end

  // Memory side: answers beats with optional random gaps and idle noise.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (burst_read || burst_write) begin
        burst_resp = nogap || ($urandom_range(0, 2) != 0);
        if (burst_resp && burst_read && rd_q.size() > 0) burst_rdata = rd_q.pop_front();
        else burst_rdata = {$urandom, $urandom};
      end else begin
        burst_resp  = noise && ($urandom_range(0, 1) == 1);
        burst_rdata = {$urandom, $urandom};
      end
    end
  end

  task automatic wait_resp(output int cycles, output logic [31:0] addr_seen,
                           output bit saw_rd, output bit saw_wr);
    bit got;
    got = 0; cycles = 0; addr_seen = '0; saw_rd = 0; saw_wr = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (burst_read || burst_write) addr_seen = burst_address;
      saw_rd |= burst_read;
      saw_wr |= burst_write;
      if (line_resp) got = 1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL wait_resp: no line_resp after %0d cycles, required within 300", cycles);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_line_rdata"}, line_rdata, '0);
    chk({tag, "_line_resp"}, 256'(line_resp), '0);
    chk({tag, "_burst_address"}, 256'(burst_address), '0);
    chk({tag, "_burst_read"}, 256'(burst_read), '0);
    chk({tag, "_burst_write"}, 256'(burst_write), '0);
    chk({tag, "_burst_wdata"}, 256'(burst_wdata), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          r0;
    int          k;
    int          n;
    logic [31:0] a;
    bit          srd;
    bit          swr;
    logic [255:0] c_wline;
    c_wline = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;

    idle_cycles(2);
    rst = 1'b0;
    chk_en = 1'b1;
    idle_cycles(3);
    chk_zero_outputs("reset");
    rst = 1'b1;
    idle_cycles(3);
    chk("idle_burst_read", 256'(burst_read), '0);
    chk("idle_burst_write", 256'(burst_write), '0);

    // Directed read with consecutive beats.
    nogap = 1;
    rd_q.delete();
    rd_q.push_back({16{4'h1}}); rd_q.push_back({16{4'h2}});
    rd_q.push_back({16{4'h3}}); rd_q.push_back({16{4'h4}});
    r0 = resp_cnt;
    line_address = 32'h0000_1234;
    line_read = 1'b1;
    wait_resp(cyc, a, srd, swr);
    line_read = 1'b0;
    chk("rd_address", 256'(a), 256'(32'h0000_1220));
    chk("rd_latency", 256'(cyc), 256'(5));
    chk("rd_line", line_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    idle_cycles(2);
    chk("rd_resp_once", 256'(resp_cnt - r0), 256'(1));

    // Directed write with random gaps.
    nogap = 0;
    wcap.delete();
    r0 = resp_cnt;
    line_address = 32'hCAFE_BABF;
    line_wdata = c_wline;
    line_write = 1'b1;
    wait_resp(cyc, a, srd, swr);
    line_write = 1'b0;
    idle_cycles(2);
    chk("wr_address", 256'(a), 256'(32'hCAFE_BAA0));
    chk("wr_beat_count", 256'(wcap.size()), 256'(4));
    if (wcap.size() == 4) begin
      chk("wr_beat0", 256'(wcap[0]), 256'(64'h8796a5b4c3d2e1f0));
      chk("wr_beat1", 256'(wcap[1]), 256'(64'h0f1e2d3c4b5a6978));
      chk("wr_beat2", 256'(wcap[2]), 256'(64'hfedcba9876543210));
      chk("wr_beat3", 256'(wcap[3]), 256'(64'h0123456789abcdef));
    end
    chk("wr_resp_once", 256'(resp_cnt - r0), 256'(1));

    // Both requests raised: write wins.
    line_address = 32'h0000_4000;
    line_read = 1'b1;
    line_write = 1'b1;
    wait_resp(cyc, a, srd, swr);
    line_read = 1'b0;
    line_write = 1'b0;
    chk("both_no_read", 256'(srd), '0);
    chk("both_write", 256'(swr), 256'(1));
    idle_cycles(1);

    // Back-to-back reads: second held straight after line_resp.
    nogap = 1;
    rd_q.delete();
    for (int i = 1; i <= 8; i++) rd_q.push_back({8{8'(i * 17)}});
    r0 = resp_cnt;
    line_address = 32'h0000_2000;
    line_read = 1'b1;
    wait_resp(cyc, a, srd, swr);
    line_address = 32'h0000_3000;
    wait_resp(cyc, a, srd, swr);
    line_read = 1'b0;
    chk("b2b_latency", 256'(cyc), 256'(6));
    chk("b2b_address", 256'(a), 256'(32'h0000_3000));
    chk("b2b_line", line_rdata, {{8{8'd136}}, {8{8'd119}}, {8{8'd102}}, {8{8'd85}}});
    idle_cycles(2);
    chk("b2b_resp_count", 256'(resp_cnt - r0), 256'(2));

    // Reset after two read beats, then a fresh read.
    rd_q.delete();
    for (int i = 0; i < 4; i++) rd_q.push_back({16{4'hA}});
    r0 = resp_cnt;
    line_address = 32'h0000_5000;
    line_read = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (burst_read && burst_resp) n++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    line_read = 1'b0;
    idle_cycles(2);
    chk_zero_outputs("midrst");
    rst = 1'b1;
    idle_cycles(2);
    chk("midrst_no_resp", 256'(resp_cnt - r0), '0);
    rd_q.delete();
    rd_q.push_back(64'h0000_0000_0000_0B00); rd_q.push_back(64'h0000_0000_0000_0B01);
    rd_q.push_back(64'h0000_0000_0000_0B02); rd_q.push_back(64'h0000_0000_0000_0B03);
    line_address = 32'h0000_6000;
    line_read = 1'b1;
    wait_resp(cyc, a, srd, swr);
    line_read = 1'b0;
    chk("fresh_line", line_rdata,
        {64'h0000_0000_0000_0B03, 64'h0000_0000_0000_0B02,
         64'h0000_0000_0000_0B01, 64'h0000_0000_0000_0B00});
    idle_cycles(1);

    // Randomized mix, checked each cycle against the model.
    rd_q.delete();
    nogap = 0;
    noise = 1;
    r0 = resp_cnt;
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 2);
      line_address = $urandom;
      for (int b = 0; b < 8; b++) line_wdata[32*b +: 32] = $urandom;
      line_read  = (k != 1);
      line_write = (k != 0);
      wait_resp(cyc, a, srd, swr);
      if ($urandom_range(0, 1) == 0) begin
        line_read = 1'b0;
        line_write = 1'b0;
        idle_cycles($urandom_range(0, 3));
      end
    end
    line_read = 1'b0;
    line_write = 1'b0;
    idle_cycles(3);
    chk("rand_resp_count", 256'(resp_cnt - r0), 256'(40));

    // Reset while idle.
    rst = 1'b0;
    idle_cycles(1);
    chk_zero_outputs("idle_rst");
    rst = 1'b1;
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
